// File: rtl/debounce_multi.sv
// debounce_multi: per-channel synchronizer, debouncer, edge pulses and press counter
module debounce_multi #(
  parameter int N_CH        = 2,
  parameter int STABLE_CNT  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int MODE        = 0
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   btn,
  output logic [N_CH-1:0]   level,
  output logic [N_CH-1:0]   press,
  output logic [N_CH-1:0]   rel,
  output logic [8*N_CH-1:0] press_cnt
);
  localparam int CW = $clog2(STABLE_CNT);
  localparam logic IDLE = ACTIVE_LOW != 0;
  localparam logic [CW-1:0] TOP = CW'(STABLE_CNT - 1);
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [7:0] pcnt;
    logic lvl, lvl_nxt, prs, rls, s, diff;
    assign s = sync[SYNC_STAGES-1] ^ IDLE;
    assign diff = s ^ lvl;
    // integrate: accept after STABLE_CNT disagreeing cycles; lockout: accept at once, then hold off
    always_comb begin
      lvl_nxt = lvl;
      cnt_nxt = '0;
      if (MODE == 0) begin
        lvl_nxt = (diff && cnt == TOP) ? s : lvl;
        cnt_nxt = (diff && cnt != TOP) ? cnt + CW'(1) : '0;
      end else begin
        lvl_nxt = (diff && cnt == '0) ? s : lvl;
        cnt_nxt = (diff && cnt == '0) ? TOP : (cnt != '0 ? cnt - CW'(1) : '0);
      end
    end
    // synchronizer chain, debounced level, edge pulses and wrapping press count
    always_ff @(posedge clk1 or negedge rst_n)
      if (!rst_n) begin
        sync <= {SYNC_STAGES{IDLE}};
        cnt  <= '0;
        lvl  <= 1'b0;
        prs  <= 1'b0;
        rls  <= 1'b0;
        pcnt <= '0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], btn[c]};
        cnt  <= cnt_nxt;
        lvl  <= lvl_nxt;
        prs  <= lvl_nxt & ~lvl;
        rls  <= ~lvl_nxt & lvl;
        pcnt <= pcnt + 8'(lvl_nxt & ~lvl);
      end
    assign level[c] = lvl;
    assign press[c] = prs;
    assign rel[c] = rls;
    assign press_cnt[8*c +: 8] = pcnt;
  end
endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed vector bench for integrate (u0) and lockout (u1) instances
module tb_debounce_multi;
  logic clk1 = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] btn = 2'b11;
  logic [1:0] lv0, pr0, rl0, lv1, pr1, rl1;
  logic [15:0] pc0, pc1;
  int nvec = 0;
  int nbad = 0;

  always #5 clk1 = ~clk1;

  debounce_multi #(.N_CH(2), .STABLE_CNT(4), .SYNC_STAGES(2), .ACTIVE_LOW(1), .MODE(0)) u0 (
    .clk1(clk1), .rst_n(rst_n), .btn(btn),
    .level(lv0), .press(pr0), .rel(rl0), .press_cnt(pc0));

  debounce_multi #(.N_CH(2), .STABLE_CNT(4), .SYNC_STAGES(2), .ACTIVE_LOW(1), .MODE(1)) u1 (
    .clk1(clk1), .rst_n(rst_n), .btn(btn),
    .level(lv1), .press(pr1), .rel(rl1), .press_cnt(pc1));

  typedef struct {
    int         n;
    logic [1:0] btn;
    logic [1:0] lv;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [15:0] pc;
  } vec_t;

  vec_t tbl [12];

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_u0", {lv0, pr0, rl0, pc0}, '0);
    chk("rst_u1", {lv1, pr1, rl1, pc1}, '0);
    btn = 2'b11;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic press_once(input logic [1:0] p);
    btn = p;
    repeat (8) step();
    btn = 2'b11;
    repeat (8) step();
  endtask

  logic [1:0] seq37 [4];
  logic [2:0] exp37 [9];

  initial begin
    tbl[0]  = '{6, 2'b10, 2'b00, 2'b00, 2'b00, 16'h0000};
    tbl[1]  = '{1, 2'b10, 2'b01, 2'b01, 2'b00, 16'h0001};
    tbl[2]  = '{1, 2'b10, 2'b01, 2'b00, 2'b00, 16'h0001};
    tbl[3]  = '{6, 2'b11, 2'b01, 2'b00, 2'b00, 16'h0001};
    tbl[4]  = '{1, 2'b11, 2'b00, 2'b00, 2'b01, 16'h0001};
    tbl[5]  = '{1, 2'b11, 2'b00, 2'b00, 2'b00, 16'h0001};
    tbl[6]  = '{6, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0001};
    tbl[7]  = '{1, 2'b00, 2'b11, 2'b11, 2'b00, 16'h0102};
    tbl[8]  = '{1, 2'b00, 2'b11, 2'b00, 2'b00, 16'h0102};
    tbl[9]  = '{6, 2'b11, 2'b11, 2'b00, 2'b00, 16'h0102};
    tbl[10] = '{1, 2'b11, 2'b00, 2'b00, 2'b11, 16'h0102};
    tbl[11] = '{2, 2'b11, 2'b00, 2'b00, 2'b00, 16'h0102};
    seq37 = '{2'b01, 2'b11, 2'b01, 2'b11};
    exp37 = '{3'b000, 3'b000, 3'b000, 3'b110, 3'b100, 3'b100, 3'b100, 3'b001, 3'b000};

    step();
    do_reset();

    // integrate mode: single press/release on ch0, then both channels together
    for (int i = 0; i < 12; i++)
      for (int k = 0; k < tbl[i].n; k++) begin
        btn = tbl[i].btn;
        chk($sformatf("int_v%0d_%0d", i, k), {lv0, pr0, rl0, pc0},
            {tbl[i].lv, tbl[i].pr, tbl[i].rl, tbl[i].pc});
        step();
      end

    // integrate mode: per-cycle bounce never settles, then a steady hold presses after 6 cycles
    do_reset();
    for (int i = 0; i < 20; i++) begin
      btn = {1'b1, i[0]};
      chk($sformatf("toggle_%0d", i), {lv0[0], pr0[0]}, 2'b00);
      step();
    end
    for (int k = 0; k < 8; k++) begin
      btn = 2'b10;
      chk($sformatf("hold_%0d", k), {lv0[0], pr0[0], pc0[7:0]},
          k == 6 ? {2'b11, 8'd1} : (k < 6 ? {2'b00, 8'd0} : {2'b10, 8'd1}));
      step();
    end

    // lockout mode: bouncing ch1 presses in cycle 3, release held off until cycle 7
    do_reset();
    for (int c = 0; c < 9; c++) begin
      btn = c < 4 ? seq37[c] : 2'b11;
      chk($sformatf("lock_%0d", c), {lv1[1], pr1[1], rl1[1]}, exp37[c]);
      step();
    end
    chk("lock_cnt", pc1, 16'h0100);

    // press counter wraps from 255 to 0 on ch0, ch1 untouched
    do_reset();
    press_once(2'b01);
    repeat (255) press_once(2'b10);
    chk("wrap255_u0", pc0, 16'h01ff);
    chk("wrap255_u1", pc1, 16'h01ff);
    press_once(2'b10);
    chk("wrap256_u0", pc0, 16'h0100);
    chk("wrap256_u1", pc1, 16'h0100);
    chk("wrap_lvl", {lv0, lv1}, 4'b0000);

    // reset mid-window clears everything; held buttons re-press with full latency
    do_reset();
    btn = 2'b01;
    repeat (8) step();
    chk("pre_rst", {lv0, pc0}, {2'b10, 16'h0100});
    btn = 2'b00;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_u0", {lv0, pr0, rl0, pc0}, '0);
    chk("mid_rst_u1", {lv1, pr1, rl1, pc1}, '0);
    step();
    chk("in_rst", {lv0, pr0, rl0, pc0}, '0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("post_rst_%0d", k), {lv0, pr0, rl0},
          k == 6 ? 6'b111100 : (k > 6 ? 6'b110000 : 6'b000000));
      step();
    end
    chk("post_rst_cnt", pc0, 16'h0101);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
